// File: rtl/pipelined_csel_addsub.sv
// Pipelined carry-select add/subtract: one BLOCK-wide slice per stage, optional signed saturation.
// Latency NSTAGE cycles; whole pipeline advances when the output register is empty or being consumed.
module pipelined_csel_addsub #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NSTAGE = WIDTH / BLOCK;

  logic adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = rst_n & adv;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
    // Operand bits not yet consumed by earlier stages; the low BLOCK bits are this stage's slice.
    localparam int RW = WIDTH - k * BLOCK;

    logic                     vld_i;
    logic [RW-1:0]            a_i;
    logic [RW-1:0]            b_i;
    logic                     op_i;
    logic                     sat_i;
    logic                     c_i;
    logic [BLOCK-1:0]         blk_a;
    logic [BLOCK-1:0]         blk_b;
    logic [BLOCK:0]           cand0;
    logic [BLOCK:0]           cand1;
    logic [BLOCK:0]           pick;
    logic [(k+1)*BLOCK-1:0]   s_nxt;

    if (k == 0) begin : g_src
      assign vld_i = in_valid;
      assign a_i   = a;
      assign b_i   = b;
      assign op_i  = op;
      assign sat_i = sat;
      assign c_i   = cin;
      assign s_nxt = pick[BLOCK-1:0];
    end else begin : g_src
      assign vld_i = g_stg[k-1].g_reg.vld_q;
      assign a_i   = g_stg[k-1].g_reg.a_q;
      assign b_i   = g_stg[k-1].g_reg.b_q;
      assign op_i  = g_stg[k-1].g_reg.op_q;
      assign sat_i = g_stg[k-1].g_reg.sat_q;
      assign c_i   = g_stg[k-1].g_reg.c_q;
      assign s_nxt = {pick[BLOCK-1:0], g_stg[k-1].g_reg.s_q};
    end

    // Both carry candidates are formed up front; the incoming carry only drives the final mux.
    assign blk_a = a_i[BLOCK-1:0];
    assign blk_b = b_i[BLOCK-1:0] ^ {BLOCK{op_i}};
    assign cand0 = {1'b0, blk_a} + {1'b0, blk_b};
    assign cand1 = cand0 + {{BLOCK{1'b0}}, 1'b1};
    assign pick  = c_i ? cand1 : cand0;

    if (k < NSTAGE - 1) begin : g_reg
      logic                   vld_q;
      logic [RW-BLOCK-1:0]    a_q;
      logic [RW-BLOCK-1:0]    b_q;
      logic [(k+1)*BLOCK-1:0] s_q;
      logic                   op_q;
      logic                   sat_q;
      logic                   c_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
        end else if (adv) begin
          vld_q <= vld_i;
          a_q   <= a_i[RW-1:BLOCK];
          b_q   <= b_i[RW-1:BLOCK];
          s_q   <= s_nxt;
          op_q  <= op_i;
          sat_q <= sat_i;
          c_q   <= pick[BLOCK];
        end
      end
    end else begin : g_out
      logic             ovf;
      logic [WIDTH-1:0] fin;

      // a_i/blk_b top bits are the effective operand MSBs here.
      assign ovf = (a_i[BLOCK-1] == blk_b[BLOCK-1]) && (s_nxt[WIDTH-1] != a_i[BLOCK-1]);

      always_comb begin
        fin = s_nxt;
        if (sat_i && ovf) fin = {a_i[BLOCK-1], {(WIDTH-1){~a_i[BLOCK-1]}}};
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          overflow  <= 1'b0;
          zero      <= 1'b0;
          negative  <= 1'b0;
        end else if (adv) begin
          out_valid <= vld_i;
          sum       <= fin;
          cout      <= pick[BLOCK];
          overflow  <= ovf;
          zero      <= ~|fin;
          negative  <= fin[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_csel_addsub.sv
// Bench for pipelined_csel_addsub: random and directed beats against an arithmetic reference,
// scoreboard queue checked by an independent output monitor.
module tb_pipelined_csel_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        op;
  logic        sat;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;
  logic        zero;
  logic        negative;

  pipelined_csel_addsub #(.WIDTH(32), .BLOCK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] res;   // {sum, cout, overflow, zero, negative}
    int          acc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rmode = 0;
  int   tog = 0;
  bit   mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [35:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mc, input logic mop, input logic msat);
    logic [31:0] eb;
    logic [32:0] full;
    logic [31:0] res;
    logic        ovf;
    eb   = mop ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, eb} + {32'd0, mc};
    res  = full[31:0];
    ovf  = (ma[31] == eb[31]) && (res[31] != ma[31]);
    if (msat && ovf) res = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return {res, full[32], ovf, (res == 32'd0), res[31]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one beat in the current cycle and hold it until accepted.
  task automatic put(input logic [31:0] pa, input logic [31:0] pb, input logic pc,
                     input logic pop, input logic psat, input bit chk, input bit push);
    int n;
    exp_t e;
    a = pa; b = pb; cin = pc; op = pop; sat = psat; in_valid = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready 0 required=accept within 200 cycles");
    end else if (push) begin
      e.res = model(pa, pb, pc, pop, psat);
      e.acc = cyc;
      e.chk_lat = chk;
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [31:0] pa, input logic [31:0] pb, input logic pc,
                      input logic pop, input logic psat, input bit chk);
    @(negedge clk);
    put(pa, pb, pc, pop, psat, chk, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom; b = $urandom;
      cin = 1'($urandom); op = 1'($urandom); sat = 1'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0 pending", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rmode)
        1: begin
          out_ready = (tog == 0);
          tog = (tog + 1) % 3;
        end
        2: out_ready = ($urandom % 4) != 0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: handshake rule, stall stability, ordering, latency and result values.
  initial begin
    bit          held;
    logic [36:0] hold_v;
    exp_t        e;
    int          lat;
    held = 0;
    hold_v = '0;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        check("in_ready_rule", {63'd0, in_ready}, {63'd0, rst_n & (~out_valid | out_ready)});
        if (held)
          check("stall_hold", {27'd0, out_valid, sum, cout, overflow, zero, negative}, {27'd0, hold_v});
        if (out_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=sum %h required=no result", sum);
          end else begin
            e = sb[0];
            if (!held) begin
              lat = cyc - e.acc;
              if (e.chk_lat) check("latency", 64'(lat), 64'd4);
              else if (lat < 4) check("min_latency", 64'(lat), 64'd4);
            end
            if (out_ready) begin
              void'(sb.pop_front());
              check("result", {28'd0, sum, cout, overflow, zero, negative}, {28'd0, e.res});
            end
          end
        end
        held = out_valid && !out_ready && rst_n;
        hold_v = {out_valid, sum, cout, overflow, zero, negative};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; op = 1'b0; sat = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {57'd0, out_valid, cout, overflow, zero, negative, in_ready, sum != 32'd0},
          64'd0);
    mon_en = 1;

    // First cycle out of reset accepts a beat.
    @(negedge clk);
    rst_n = 1'b1;
    put(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1); drain();
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1); drain();
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b1); drain();
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b1); drain();
    send(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1); drain();
    send(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b1); drain();

    // Back-to-back beats against an out_ready pattern of 1,0,0 repeating.
    rmode = 1;
    tog = 0;
    for (int i = 0; i < 8; i++)
      send($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    drain();

    rmode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 4 == 0) idle(1 + $urandom % 3);
      if (i % 5 == 0)
        send({1'($urandom), 31'h7FFF_FFFF}, $urandom % 4, 1'($urandom), 1'($urandom),
             1'($urandom), 1'b0);
      else
        send($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end
    drain();

    // Reset with three beats in flight: none of them may surface.
    rmode = 0;
    idle(2);
    send(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, 1'b0, 1'b0);
    put(32'h0000_0033, 32'h0000_0044, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.delete();
    @(negedge clk);
    put(32'h0000_0055, 32'h0000_0066, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    put(32'h0000_0077, 32'h0000_0088, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_reset_valid", {63'd0, out_valid}, 64'd0);
    put(32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
